// File: rtl/div_sign_stage.sv
// Signed wrapper around the unsigned iterative divider core: magnitudes in, signs reapplied out.
// Optional DIV_REMAINDER_EN adds a signed remainder output (sign follows the dividend).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for ctrl_DIV; operands and signs latched on accept
//   LOAD   | core_start pulse, magnitudes already on core_dividend/divisor
//   RUN    | waiting for core_ready (first cycle ignores a stale ready)
//   FIX    | reapply signs to the captured quotient/remainder
//   DONE   | data_resultRDY strobe, then back to IDLE
module div_sign_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic             core_start,
   output logic [WIDTH-1:0] core_dividend,
   output logic [WIDTH-1:0] core_divisor,
   input  logic             core_ready,
   input  logic [WIDTH-1:0] core_quotient,
   input  logic [WIDTH-1:0] core_remainder,
`ifdef DIV_REMAINDER_EN
   output logic [WIDTH-1:0] data_remainder,
`endif
   output logic [WIDTH-1:0] data_result,
   output logic             data_resultRDY,
   output logic             data_exception,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_b_zero;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   logic             r_start;
   logic             r_busy;
   logic             r_rdy;
   logic             r_exc;
   logic             r_run_armed;
   logic             r_sign_q;
   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_result;

   assign w_b_zero = (data_operandB == '0);
   assign w_mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign w_mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ctrl_DIV) begin
               w_accept = 1'b1;
               w_next   = w_b_zero ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: w_next = S_RUN;
         // r_run_armed is low in the first RUN cycle, masking the previous op's ready
         S_RUN: begin
            if (r_run_armed && core_ready) begin
               w_next = S_FIX;
            end
         end
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_rdy       <= 1'b0;
         r_exc       <= 1'b0;
         r_run_armed <= 1'b0;
         r_sign_q    <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_quot      <= '0;
         r_result    <= '0;
      end else begin
         r_state     <= w_next;
         r_start     <= (w_next == S_LOAD);
         r_busy      <= (w_next != S_IDLE);
         r_rdy       <= (w_next == S_DONE);
         r_run_armed <= (r_state == S_RUN);
         if (w_accept) begin
            r_dividend <= w_mag_a;
            r_divisor  <= w_mag_b;
            r_sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_exc      <= w_b_zero;
            if (w_b_zero) begin
               r_result <= '0;
            end
         end
         if ((r_state == S_RUN) && (w_next == S_FIX)) begin
            r_quot <= core_quotient;
         end
         if (r_state == S_FIX) begin
            r_result <= r_sign_q ? -r_quot : r_quot;
         end
      end
   end

`ifdef DIV_REMAINDER_EN
   logic             r_sign_r;
   logic [WIDTH-1:0] r_rem_cap;
   logic [WIDTH-1:0] r_remainder;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sign_r    <= 1'b0;
         r_rem_cap   <= '0;
         r_remainder <= '0;
      end else begin
         if (w_accept) begin
            r_sign_r <= data_operandA[WIDTH-1];
            if (w_b_zero) begin
               r_remainder <= '0;
            end
         end
         if ((r_state == S_RUN) && (w_next == S_FIX)) begin
            r_rem_cap <= core_remainder;
         end
         if (r_state == S_FIX) begin
            r_remainder <= r_sign_r ? -r_rem_cap : r_rem_cap;
         end
      end
   end

   assign data_remainder = r_remainder;
`else
   logic w_unused_rem;
   assign w_unused_rem = ^core_remainder;
`endif

   assign core_start     = r_start;
   assign core_dividend  = r_dividend;
   assign core_divisor   = r_divisor;
   assign data_result    = r_result;
   assign data_resultRDY = r_rdy;
   assign data_exception = r_exc;
   assign busy           = r_busy;

endmodule

// File: tb/tb_div_sign_stage.sv
// Bench for div_sign_stage: behavioural core model, per-cycle timeline model, signed arithmetic reference.
// Honours DIV_REMAINDER_EN to connect and check data_remainder.
module tb_div_sign_stage;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         ctrl_DIV = 1'b0;
   logic [W-1:0] opA = '0;
   logic [W-1:0] opB = '0;
   logic         core_start;
   logic [W-1:0] core_dividend;
   logic [W-1:0] core_divisor;
   logic         core_ready = 1'b0;
   logic [W-1:0] core_quotient = '0;
   logic [W-1:0] core_remainder = '0;
   logic [W-1:0] data_result;
   logic         data_resultRDY;
   logic         data_exception;
   logic         busy;
`ifdef DIV_REMAINDER_EN
   logic [W-1:0] data_remainder;
`endif

   div_sign_stage #(.WIDTH(W)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .ctrl_DIV(ctrl_DIV),
      .data_operandA(opA),
      .data_operandB(opB),
      .core_start(core_start),
      .core_dividend(core_dividend),
      .core_divisor(core_divisor),
      .core_ready(core_ready),
      .core_quotient(core_quotient),
      .core_remainder(core_remainder),
`ifdef DIV_REMAINDER_EN
      .data_remainder(data_remainder),
`endif
      .data_result(data_result),
      .data_resultRDY(data_resultRDY),
      .data_exception(data_exception),
      .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference arithmetic on 64-bit signed integers
   function automatic logic [W-1:0] m_quot(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return '0;
      q = sa / sb;
      return q[W-1:0];
   endfunction

   function automatic logic [W-1:0] m_rem(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return '0;
      r = sa % sb;
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] m_mag(input logic [W-1:0] a);
      longint sa;
      sa = longint'($signed(a));
      if (sa < 0) sa = -sa;
      return sa[W-1:0];
   endfunction

   // Unsigned divider core: ready rises core_lat cycles after the start cycle.
   // A lazy core leaves its old ready high through the first cycle after start.
   int core_lat = 3;
   bit core_lazy = 1'b0;
   int core_cnt = 0;
   int core_stale = 0;
   always begin
      @(posedge clock);
      #1;
      if (core_start) begin
         core_cnt = core_lat;
         if (core_lazy && core_ready) core_stale = 2;
         else begin
            core_ready = 1'b0;
            core_stale = 0;
         end
      end else begin
         if (core_stale > 0) begin
            core_stale--;
            if (core_stale == 0) core_ready = 1'b0;
         end
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_ready = 1'b1;
               if (core_divisor != '0) begin
                  core_quotient  = core_dividend / core_divisor;
                  core_remainder = core_dividend % core_divisor;
               end
            end
         end
      end
   end

   // Timeline of the current operation, written by the driver only
   bit           rec_valid = 1'b0;
   int           rec_n = 0;
   int           rec_end = 0;
   bit           rec_div0 = 1'b0;
   logic [W-1:0] rec_res = '0, rec_rem = '0, rec_prev_res = '0, rec_prev_rem = '0;
   logic [W-1:0] rec_mag_a = '0, rec_mag_b = '0;
   bit           rec_exc = 1'b0, rec_prev_exc = 1'b0;
   bit           tb_done = 1'b0;

   task automatic wait_to(input int t);
      while (cyc < t) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input bit lazy, input bit poke, input bit do_reset);
      int n;
      core_lat     = lat;
      core_lazy    = lazy;
      n            = cyc;
      rec_prev_res = rec_valid ? rec_res : '0;
      rec_prev_rem = rec_valid ? rec_rem : '0;
      rec_prev_exc = rec_valid ? rec_exc : 1'b0;
      rec_n        = n;
      rec_div0     = (b == '0);
      rec_end      = rec_div0 ? n + 1 : n + 3 + lat;
      rec_res      = m_quot(a, b);
      rec_rem      = m_rem(a, b);
      rec_exc      = rec_div0;
      rec_mag_a    = m_mag(a);
      rec_mag_b    = m_mag(b);
      rec_valid    = 1'b1;
      ctrl_DIV     = 1'b1;
      opA          = a;
      opB          = b;
      @(posedge clock);
      #2;
      ctrl_DIV = 1'b0;
      opA      = $urandom;
      opB      = $urandom;
      if (do_reset && !rec_div0) begin
         wait_to(n + 3);
         rec_valid = 1'b0;
         reset_n   = 1'b0;
         @(posedge clock);
         #2;
         reset_n = 1'b1;
      end else begin
         if (poke && !rec_div0) begin
            wait_to(n + 2 + $urandom_range(0, lat));
            ctrl_DIV = 1'b1;
            opA      = $urandom;
            opB      = $urandom_range(1, 50);
            @(posedge clock);
            #2;
            ctrl_DIV = 1'b0;
         end
         wait_to(rec_end + 1 + $urandom_range(0, 2));
      end
   endtask

   initial begin
      logic [W-1:0] a, b;
      int sel, lat;
      bit rst;
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b1;
      wait_to(cyc + 2);
      issue(32'd7, 32'd2, 34, 1'b0, 1'b0, 1'b0);
      issue(32'hFFFF_FFF9, 32'd2, 5, 1'b1, 1'b0, 1'b0);
      issue(32'd7, 32'hFFFF_FFFE, 4, 1'b0, 1'b0, 1'b0);
      issue(32'd5, 32'd0, 3, 1'b0, 1'b0, 1'b0);
      issue(32'd9, 32'd4, 3, 1'b1, 1'b0, 1'b0);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 6, 1'b0, 1'b0, 1'b0);
      issue(32'd100, 32'd7, 10, 1'b1, 1'b1, 1'b0);
      issue(32'd1000, 32'd3, 20, 1'b0, 1'b0, 1'b1);
      issue(32'hFFFF_FC18, 32'd3, 8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 7);
         a   = $urandom;
         b   = $urandom;
         case (sel)
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
            3: b = $urandom_range(1, 9);
            default: ;
         endcase
         lat = $urandom_range(3, 40);
         rst = ($urandom_range(0, 9) == 0) && (lat >= 5);
         issue(a, b, lat, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rst);
      end
      wait_to(cyc + 3);
      tb_done = 1'b1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   initial begin
      logic         e_busy, e_start, e_rdy, e_exc, e_core;
      logic [W-1:0] e_res, e_rem, e_ma, e_mb;
      chk("pin_pos_q", m_quot(32'd7, 32'd2), 32'd3);
      chk("pin_pos_r", m_rem(32'd7, 32'd2), 32'd1);
      chk("pin_neg_q", m_quot(32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("pin_neg_r", m_rem(32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("pin_negb_q", m_quot(32'd7, 32'hFFFF_FFFE), 32'hFFFF_FFFD);
      chk("pin_negb_r", m_rem(32'd7, 32'hFFFF_FFFE), 32'd1);
      chk("pin_ovf_q", m_quot(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("pin_mag_min", m_mag(32'h8000_0000), 32'h8000_0000);
      chk("pin_mag_neg7", m_mag(32'hFFFF_FFF9), 32'd7);
      while (!tb_done && cyc < 20000) begin
         @(negedge clock);
         e_ma = '0;
         e_mb = '0;
         if (!rec_valid) begin
            e_busy = 0; e_start = 0; e_rdy = 0; e_exc = 0;
            e_res = '0; e_rem = '0; e_core = 1;
         end else if (cyc <= rec_n) begin
            e_busy = 0; e_start = 0; e_rdy = 0; e_exc = rec_prev_exc;
            e_res = rec_prev_res; e_rem = rec_prev_rem; e_core = 0;
         end else begin
            e_busy  = (cyc <= rec_end);
            e_start = !rec_div0 && (cyc == rec_n + 1);
            e_rdy   = (cyc == rec_end);
            e_exc   = rec_exc;
            e_res   = (cyc >= rec_end) ? rec_res : rec_prev_res;
            e_rem   = rec_div0 ? '0 : ((cyc >= rec_end) ? rec_rem : rec_prev_rem);
            e_core  = !rec_div0 && (cyc <= rec_end);
            e_ma    = rec_mag_a;
            e_mb    = rec_mag_b;
         end
         chk("busy", W'(busy), W'(e_busy));
         chk("core_start", W'(core_start), W'(e_start));
         chk("resultRDY", W'(data_resultRDY), W'(e_rdy));
         chk("exception", W'(data_exception), W'(e_exc));
         chk("result", data_result, e_res);
`ifdef DIV_REMAINDER_EN
         chk("remainder", data_remainder, e_rem);
`endif
         if (e_core) begin
            chk("core_dividend", core_dividend, e_ma);
            chk("core_divisor", core_divisor, e_mb);
         end
      end
      if (!tb_done) begin
         errors++;
         $display("FAIL timeout cyc=%0d got=running exp=done", cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
